// File: rtl/memory_stage.sv
// Memory stage: data memory, downward-growing stack pointer, and the two-cycle
// CALL/INT push and RET/RTI pop sequencer feeding reg_mem_WB.
module memory_stage #(
  parameter int unsigned        ADDR_W  = 11,
  parameter logic [ADDR_W-1:0]  SP_INIT = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       EXMEM_ALU_result,
  input  logic [15:0]       EXMEM_storeData,
  input  logic [15:0]       EXMEM_PC,
  input  logic [2:0]        EXMEM_flags,
  input  logic [2:0]        EXMEM_Rdst_address,
  input  logic              EXMEM_memRead,
  input  logic              EXMEM_memWrite,
  input  logic              EXMEM_Push,
  input  logic              EXMEM_Pop,
  input  logic              EXMEM_Call,
  input  logic              EXMEM_Ret,
  input  logic              EXMEM_WB,
  input  logic [1:0]        EXMEM_shmnt,
  output logic [15:0]       dataFromMemory,
  output logic [15:0]       MEMWB_ALU_result,
  output logic [2:0]        MEMWB_Rdst_address,
  output logic              MEMWB_memRead,
  output logic              MEMWB,
  output logic [1:0]        shmnt,
  output logic              Pop,
  output logic              stall,
  output logic [15:0]       retPC,
  output logic [2:0]        retFlags,
  output logic              retValid,
  output logic [ADDR_W-1:0] SP
);

  typedef enum logic [1:0] {IDLE, CALL2, RET2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [2:0]        ret_flags_q, ret_flags_d;
  logic [15:0]       mem_q [1 << ADDR_W];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;
  logic              bubble;
  logic [ADDR_W-1:0] addr, sp_inc, sp_dec;
  logic [15:0]       rd_stack, rd_addr;

  assign addr     = EXMEM_ALU_result[ADDR_W-1:0];
  assign sp_inc   = sp_q + 1'b1;
  assign sp_dec   = sp_q - 1'b1;
  assign rd_stack = mem_q[sp_inc];
  assign rd_addr  = mem_q[addr];

  // Everything stays quiet while rst_n is low, so a reset landing in CALL2
  // suppresses the second push and one landing in RET2 suppresses retValid.
  always_comb begin
    state_d        = state_q;
    sp_d           = sp_q;
    ret_flags_d    = ret_flags_q;
    mem_we         = 1'b0;
    mem_waddr      = sp_q;
    mem_wdata      = '0;
    stall          = 1'b0;
    retValid       = 1'b0;
    retPC          = '0;
    dataFromMemory = '0;
    bubble         = 1'b1;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          bubble = 1'b0;
          if (EXMEM_Call) begin
            mem_we    = 1'b1;
            mem_wdata = EXMEM_PC;
            sp_d      = sp_dec;
            stall     = 1'b1;
            bubble    = 1'b1;
            state_d   = CALL2;
          end else if (EXMEM_Ret) begin
            ret_flags_d = rd_stack[2:0];
            sp_d        = sp_inc;
            stall       = 1'b1;
            bubble      = 1'b1;
            state_d     = RET2;
          end else if (EXMEM_Push) begin
            mem_we    = 1'b1;
            mem_wdata = EXMEM_storeData;
            sp_d      = sp_dec;
          end else if (EXMEM_Pop) begin
            dataFromMemory = rd_stack;
            sp_d           = sp_inc;
          end else if (EXMEM_memWrite) begin
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wdata = EXMEM_storeData;
          end else if (EXMEM_memRead) begin
            dataFromMemory = rd_addr;
          end
        end
        CALL2: begin
          mem_we    = 1'b1;
          mem_wdata = {13'b0, EXMEM_flags};
          sp_d      = sp_dec;
          state_d   = IDLE;
        end
        RET2: begin
          retPC    = rd_stack;
          retValid = 1'b1;
          sp_d     = sp_inc;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sp_q        <= SP_INIT;
      ret_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      ret_flags_q <= ret_flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign MEMWB_ALU_result   = EXMEM_ALU_result;
  assign MEMWB_Rdst_address = EXMEM_Rdst_address;
  assign shmnt              = EXMEM_shmnt;
  assign MEMWB              = EXMEM_WB & ~bubble;
  assign MEMWB_memRead      = (EXMEM_memRead | EXMEM_Pop) & ~bubble;
  assign Pop                = EXMEM_Pop & ~bubble;
  assign retFlags           = ret_flags_q;
  assign SP                 = sp_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural stack/memory model.
module tb_memory_stage;

  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   EXMEM_ALU_result, EXMEM_storeData, EXMEM_PC;
  logic [2:0]    EXMEM_flags, EXMEM_Rdst_address;
  logic          EXMEM_memRead, EXMEM_memWrite, EXMEM_Push, EXMEM_Pop;
  logic          EXMEM_Call, EXMEM_Ret, EXMEM_WB;
  logic [1:0]    EXMEM_shmnt;
  logic [15:0]   dataFromMemory, MEMWB_ALU_result, retPC;
  logic [2:0]    MEMWB_Rdst_address, retFlags;
  logic          MEMWB_memRead, MEMWB, Pop, stall, retValid;
  logic [1:0]    shmnt;
  logic [AW-1:0] SP;

  always #5 clk = ~clk;

  memory_stage #(.ADDR_W(AW), .SP_INIT(11'h7FF)) dut (
    .clk(clk), .rst_n(rst_n),
    .EXMEM_ALU_result(EXMEM_ALU_result), .EXMEM_storeData(EXMEM_storeData),
    .EXMEM_PC(EXMEM_PC), .EXMEM_flags(EXMEM_flags),
    .EXMEM_Rdst_address(EXMEM_Rdst_address), .EXMEM_memRead(EXMEM_memRead),
    .EXMEM_memWrite(EXMEM_memWrite), .EXMEM_Push(EXMEM_Push), .EXMEM_Pop(EXMEM_Pop),
    .EXMEM_Call(EXMEM_Call), .EXMEM_Ret(EXMEM_Ret), .EXMEM_WB(EXMEM_WB),
    .EXMEM_shmnt(EXMEM_shmnt), .dataFromMemory(dataFromMemory),
    .MEMWB_ALU_result(MEMWB_ALU_result), .MEMWB_Rdst_address(MEMWB_Rdst_address),
    .MEMWB_memRead(MEMWB_memRead), .MEMWB(MEMWB), .shmnt(shmnt), .Pop(Pop),
    .stall(stall), .retPC(retPC), .retFlags(retFlags), .retValid(retValid), .SP(SP)
  );

  int unsigned nvec  = 0;
  int unsigned nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: memory with per-word "known" tracking, SP, pending second word of a
  // two-word stack op (0 none, 1 flags push, 2 PC pop), and the popped flags.
  logic [15:0]   mmem   [DEPTH];
  bit            mknown [DEPTH];
  logic [AW-1:0] msp;
  int            mpend   = 0;
  logic [2:0]    mflags;
  bit            mfk     = 1'b0;
  bit            started = 1'b0;
  logic [AW-1:0] spp, maddr;

  assign spp   = msp + 1'b1;
  assign maddr = EXMEM_ALU_result[AW-1:0];

  always @(posedge clk) begin
    started <= 1'b1;
    if (!rst_n) begin
      msp <= 11'h7FF; mpend <= 0; mflags <= 3'd0; mfk <= 1'b1;
    end else if (mpend == 1) begin
      mmem[msp] <= {13'b0, EXMEM_flags}; mknown[msp] <= 1'b1;
      msp <= msp - 1'b1; mpend <= 0;
    end else if (mpend == 2) begin
      msp <= spp; mpend <= 0;
    end else if (EXMEM_Call) begin
      mmem[msp] <= EXMEM_PC; mknown[msp] <= 1'b1;
      msp <= msp - 1'b1; mpend <= 1;
    end else if (EXMEM_Ret) begin
      mflags <= mmem[spp][2:0]; mfk <= mknown[spp];
      msp <= spp; mpend <= 2;
    end else if (EXMEM_Push) begin
      mmem[msp] <= EXMEM_storeData; mknown[msp] <= 1'b1;
      msp <= msp - 1'b1;
    end else if (EXMEM_Pop) begin
      msp <= spp;
    end else if (EXMEM_memWrite) begin
      mmem[maddr] <= EXMEM_storeData; mknown[maddr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("SP", SP, msp);
      chk("ALU pass", MEMWB_ALU_result, EXMEM_ALU_result);
      chk("Rdst pass", MEMWB_Rdst_address, EXMEM_Rdst_address);
      chk("shmnt pass", shmnt, EXMEM_shmnt);
      if (mfk) chk("retFlags", retFlags, mflags);
      if (!rst_n || mpend != 0 || EXMEM_Call || EXMEM_Ret) begin
        chk("stall", stall, rst_n && mpend == 0 && (EXMEM_Call || EXMEM_Ret));
        chk("retValid", retValid, rst_n && mpend == 2);
        chk("MEMWB bubble", MEMWB, 0);
        chk("memRead bubble", MEMWB_memRead, 0);
        chk("Pop bubble", Pop, 0);
        if (rst_n && mpend == 2 && mknown[spp]) chk("retPC", retPC, mmem[spp]);
      end else begin
        chk("stall", stall, 0);
        chk("retValid", retValid, 0);
        chk("MEMWB", MEMWB, EXMEM_WB);
        chk("MEMWB_memRead", MEMWB_memRead, EXMEM_memRead | EXMEM_Pop);
        chk("Pop", Pop, EXMEM_Pop);
        if (EXMEM_Push || (!EXMEM_Pop && EXMEM_memWrite) ||
            (!EXMEM_Pop && !EXMEM_memRead))
          chk("data idle", dataFromMemory, 0);
        else if (EXMEM_Pop) begin
          if (mknown[spp]) chk("data pop", dataFromMemory, mmem[spp]);
        end else if (mknown[maddr])
          chk("data load", dataFromMemory, mmem[maddr]);
      end
    end
  end

  task automatic clr();
    EXMEM_memRead = 0; EXMEM_memWrite = 0; EXMEM_Push = 0; EXMEM_Pop = 0;
    EXMEM_Call = 0; EXMEM_Ret = 0; EXMEM_WB = 1;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    int unsigned a;
    rst_n = 0; clr();
    EXMEM_ALU_result = '0; EXMEM_storeData = '0; EXMEM_PC = '0; EXMEM_flags = '0;
    EXMEM_Rdst_address = 3'd2; EXMEM_shmnt = 2'd1;
    nxt(); nxt(); rst_n = 1;

    EXMEM_memWrite = 1; EXMEM_ALU_result = 16'h0005; EXMEM_storeData = 16'h1234;
    neg(); chk("reset SP", SP, 11'h7FF); chk("reset stall", stall, 0);
    nxt(); clr(); EXMEM_memRead = 1;
    neg(); chk("load 5", dataFromMemory, 16'h1234);

    nxt(); clr(); EXMEM_Push = 1; EXMEM_storeData = 16'hAAAA;
    nxt(); EXMEM_storeData = 16'hBBBB;
    neg(); chk("push2 SP", SP, 11'h7FE);
    nxt(); clr(); EXMEM_Pop = 1;
    neg(); chk("pop1 data", dataFromMemory, 16'hBBBB); chk("pop1 Pop", Pop, 1);
    chk("pop1 SP", SP, 11'h7FD);
    nxt(); neg(); chk("pop2 data", dataFromMemory, 16'hAAAA);
    nxt(); clr(); neg(); chk("pops SP", SP, 11'h7FF);

    nxt(); clr(); EXMEM_Call = 1; EXMEM_PC = 16'h0040; EXMEM_flags = 3'b101;
    neg(); chk("call1 stall", stall, 1); chk("call1 MEMWB", MEMWB, 0);
    nxt(); neg(); chk("call2 stall", stall, 0); chk("call2 MEMWB", MEMWB, 0);
    nxt(); clr(); EXMEM_memRead = 1; EXMEM_ALU_result = 16'h07FF;
    neg(); chk("call PC word", dataFromMemory, 16'h0040); chk("call SP", SP, 11'h7FD);
    nxt(); EXMEM_ALU_result = 16'h07FE;
    neg(); chk("call flag word", dataFromMemory, 16'h0005);
    nxt(); clr(); EXMEM_Ret = 1;
    neg(); chk("ret1 stall", stall, 1); chk("ret1 MEMWB", MEMWB, 0); chk("ret1 valid", retValid, 0);
    nxt(); neg(); chk("ret2 flags", retFlags, 3'b101); chk("ret2 valid", retValid, 1);
    chk("ret2 PC", retPC, 16'h0040); chk("ret2 stall", stall, 0); chk("ret2 MEMWB", MEMWB, 0);
    nxt(); clr(); neg(); chk("ret SP", SP, 11'h7FF); chk("ret after valid", retValid, 0);

    nxt(); EXMEM_memWrite = 1; EXMEM_ALU_result = 16'h0000; EXMEM_storeData = 16'h0BAD;
    nxt(); clr(); EXMEM_Pop = 1;
    neg(); chk("wrap pop data", dataFromMemory, 16'h0BAD);
    nxt(); clr(); EXMEM_Push = 1; EXMEM_storeData = 16'hC0DE;
    neg(); chk("wrap SP 0", SP, 11'h000);
    nxt(); clr(); EXMEM_memRead = 1; EXMEM_ALU_result = 16'h0000;
    neg(); chk("wrap push data", dataFromMemory, 16'hC0DE); chk("wrap SP back", SP, 11'h7FF);

    nxt(); clr(); EXMEM_memWrite = 1; EXMEM_ALU_result = 16'h0009; EXMEM_storeData = 16'h1111;
    nxt(); EXMEM_Push = 1; EXMEM_storeData = 16'h2222;
    nxt(); clr(); EXMEM_memRead = 1;
    neg(); chk("prio mem kept", dataFromMemory, 16'h1111); chk("prio SP", SP, 11'h7FE);
    nxt(); clr(); EXMEM_Pop = 1;
    neg(); chk("prio pushed", dataFromMemory, 16'h2222);

    nxt(); clr(); EXMEM_memWrite = 1; EXMEM_ALU_result = 16'h07FE; EXMEM_storeData = 16'h3333;
    nxt(); clr(); EXMEM_Call = 1; EXMEM_PC = 16'h0077; EXMEM_flags = 3'b010;
    neg(); chk("rcall1 stall", stall, 1);
    nxt(); rst_n = 0;
    neg(); chk("rcall2 stall", stall, 0);
    nxt(); rst_n = 1; clr();
    neg(); chk("rcall SP", SP, 11'h7FF); chk("rcall idle stall", stall, 0);
    nxt(); EXMEM_memRead = 1; EXMEM_ALU_result = 16'h07FE;
    neg(); chk("rcall no 2nd word", dataFromMemory, 16'h3333);

    for (int i = 0; i < 4000; i++) begin
      nxt();
      rst_n          = ($urandom_range(0, 249) != 0);
      EXMEM_Call     = ($urandom_range(0, 99) < 4);
      EXMEM_Ret      = ($urandom_range(0, 99) < 4);
      EXMEM_Push     = ($urandom_range(0, 99) < 20);
      EXMEM_Pop      = ($urandom_range(0, 99) < 20);
      EXMEM_memWrite = ($urandom_range(0, 99) < 25);
      EXMEM_memRead  = ($urandom_range(0, 99) < 35);
      EXMEM_WB       = 1'($urandom);
      a = $urandom_range(0, 1) ? $urandom_range(0, 15) : 32'd2040 + $urandom_range(0, 7);
      EXMEM_ALU_result   = 16'(($urandom_range(0, 31) << 11) | a);
      EXMEM_storeData    = 16'($urandom);
      EXMEM_PC           = 16'($urandom);
      EXMEM_flags        = 3'($urandom);
      EXMEM_Rdst_address = 3'($urandom);
      EXMEM_shmnt        = 2'($urandom);
    end
    nxt(); neg();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline memory stage between the EX/MEM pipeline register and `reg_mem_WB`. It holds the data memory and the stack pointer. It executes loads, stores, PUSH, POP, two-word CALL/INT pushes and two-word RET/RTI pops, and drives the signals that `reg_mem_WB` captures on the falling clock edge. Two-word stack operations take two cycles; during the first cycle the block stalls the upstream stages with a single `stall` signal.

## Interface
- `ADDR_W`, default 11: data memory depth is 2^ADDR_W 16-bit words; all addresses and SP are ADDR_W bits.
- `SP_INIT`, default 2^ADDR_W-1: stack pointer value after reset.

- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- `EXMEM_ALU_result`  in  16  load/store address (low ADDR_W bits) or pass-through result.
- `EXMEM_storeData`  in  16  data for store/PUSH.
- `EXMEM_PC`  in  16  return PC for CALL.
- `EXMEM_flags`  in  3  flags pushed by CALL.
- `EXMEM_Rdst_address`  in  3  destination register.
- `EXMEM_memRead`, `EXMEM_memWrite`, `EXMEM_Push`, `EXMEM_Pop`, `EXMEM_Call`, `EXMEM_Ret`, `EXMEM_WB`  in  1 each  operation/control bits.
- `EXMEM_shmnt`  in  2  pass-through.
- `dataFromMemory`  out  16  read data to `reg_mem_WB`.
- `MEMWB_ALU_result`  out  16  pass-through of `EXMEM_ALU_result`.
- `MEMWB_Rdst_address`  out  3  pass-through.
- `MEMWB_memRead`  out  1  `EXMEM_memRead | EXMEM_Pop`, gated by bubble.
- `MEMWB`  out  1  `EXMEM_WB`, gated by bubble.
- `shmnt`  out  2  pass-through.
- `Pop`  out  1  `EXMEM_Pop`, gated by bubble.
- `stall`  out  1  freeze IF/ID/EX and the EX/MEM register.
- `retPC`  out  16  popped PC; valid only when `retValid`=1.
- `retFlags`  out  3  popped flags, registered.
- `retValid`  out  1  one-cycle strobe; the fetch stage loads `retPC`.
- `SP`  out  ADDR_W  current stack pointer.

## Operation
- Stack grows downward. SP points at the next free word.
- Operation priority, one per cycle: Call > Ret > Push > Pop > memWrite > memRead. Lower-priority bits are ignored when a higher one is set.
- Memory read is combinational from the array. Writes and SP updates happen on posedge.
- **memRead:** `dataFromMemory` = mem[ALU_result[ADDR_W-1:0]].
- **memWrite:** mem[addr] <= storeData.
- **Push:** mem[SP] <= storeData; SP <= SP-1.
- **Pop:** `dataFromMemory` = mem[SP+1]; SP <= SP+1.
- SP arithmetic is modulo 2^ADDR_W, so wrap-around is silent. Pop at SP=2^ADDR_W-1 reads mem[0] and sets SP=0.
- When no read is active, `dataFromMemory` = 0.

FSM states are IDLE, CALL2, RET2.
- **IDLE + Call:** mem[SP] <= PC; SP <= SP-1; `stall`=1; bubble; go to CALL2.
- **CALL2:** mem[SP] <= {13'b0, flags}; SP <= SP-1; `stall`=0; bubble; go to IDLE.
- **IDLE + Ret:** read flags from mem[SP+1]; retFlags <= mem[SP+1][2:0]; SP <= SP+1; `stall`=1; bubble; go to RET2.
- **RET2:** `retPC` = mem[SP+1]; `retValid`=1; SP <= SP+1; `stall`=0; bubble; go to IDLE.
- In CALL2/RET2 the inputs are ignored. Upstream holds them stable, but the FSM does not depend on that.
- **Bubble:** `MEMWB`, `MEMWB_memRead`, `Pop` forced to 0. This applies to both cycles of Call/Ret.
- **Write/read same address, same cycle:** the read returns the old contents.

## Timing
- **Reset** (`rst_n`=0 at posedge):
  - SP=SP_INIT, state=IDLE, retFlags=0.
  - `stall`, `retValid` and the gated outputs evaluate to 0 while `rst_n`=0.
  - Memory contents are not reset.
- **Reset mid-operation:** in CALL2 the second word is not written; in RET2 `retValid` is not issued. The next cycle is IDLE with SP=SP_INIT.
- **Latency:** pass-through and read data are combinational, valid before the negedge capture by `reg_mem_WB`. SP and memory update at the posedge that ends the cycle.
- **Call/Ret:** exactly 2 cycles. `stall` is high only in cycle 1. `retValid` is high only in RET2.
- **Back-to-back:** a Call/Ret arriving in the cycle after CALL2/RET2 starts a new sequence immediately from IDLE.

## Test plan
- **Reset, then SP:** reset, then store 0x1234 at address 5 and load from 5. Expect SP=0x7FF and `dataFromMemory`=0x1234 in the load cycle.
- **Push/Pop:** push 0xAAAA then push 0xBBBB; SP goes 0x7FF→0x7FE→0x7FD. Pop returns 0xBBBB with SP=0x7FE and `Pop`=1. Second pop returns 0xAAAA with SP=0x7FF.
- **Call then Ret:** Call with PC=0x0040, flags=3'b101. Expect `stall`=1 only in cycle 1, mem[0x7FF]=0x0040, mem[0x7FE]=0x0005, SP=0x7FD. Ret gives retFlags=3'b101 after cycle 1, then `retPC`=0x0040 with `retValid`=1 in cycle 2, SP=0x7FF. `MEMWB`=0 in all four cycles.
- **Wrap:** Pop at SP=0x7FF reads mem[0] and sets SP=0x000. Push at SP=0 writes mem[0] and sets SP=0x7FF.
- **Priority:** Push and memWrite both asserted. Only the push occurs; mem[addr] is unchanged.
- **Reset in CALL2:** assert `rst_n`=0 during CALL2. mem[SP_INIT-1] is not written, SP=0x7FF, `stall`=0.
